updown_counter_mod: RTL and testbench

UPDOWN_COUNTER_MOD -- requirements
Module: updown_counter_mod

---
 rtl/updown_counter_pkg.sv | 28 ++
 rtl/updown_counter_mod_next_calc.sv | 77 +++++++
 rtl/updown_counter_mod.sv | 121 ++++++++++++
 tb/tb_updown_counter_mod.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter_pkg
//  Purpose  : Shared constants for the up/down counter slice: boundary-mode
//             and direction encodings, plus the default terminal-value helper.
//  Revision : 1.0  initial release
// ============================================================================
package updown_counter_pkg;

   // Boundary handling selected by the mode input
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Count direction selected by the up_down input
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;

   // Largest value representable in 'width' bits; 32 bits is handled apart
   // so the shift never has to produce 2**32 in a 32-bit expression.
   function automatic int unsigned default_max(input int unsigned width);
      if (width >= 32)
         return 32'hFFFF_FFFF;
      else
         return (32'd1 << width) - 32'd1;
   endfunction

endpackage : updown_counter_pkg
`default_nettype wire

// File: rtl/updown_counter_mod_next_calc.sv
`default_nettype none
// ============================================================================
//  Module   : ctr_next_calc
//  Purpose  : Purely combinational next-count arithmetic for the up/down
//             counter. Detects crossing of 0 / MAX_VAL and applies wrap or
//             saturate behaviour. Holds no state.
//  Revision : 1.0  initial release
// ============================================================================
module ctr_next_calc
   import updown_counter_pkg::*;
#(
   parameter int          WIDTH   = 8,
   parameter int          STEP_W  = 4,
   parameter int unsigned MAX_VAL = 255
) (
   input  logic [WIDTH-1:0]  i_count,
   input  logic [STEP_W-1:0] i_step,
   input  logic              i_up_down,
   input  logic              i_mode,
   output logic [WIDTH-1:0]  o_next,
   output logic              o_boundary
);

   // One extra bit beyond count+step so neither the sum nor MAX_VAL+1
   // can lose a carry.
   localparam int             AW    = WIDTH + STEP_W + 1;
   localparam logic [AW-1:0]  c_MAX = AW'(MAX_VAL);
   localparam logic [AW-1:0]  c_MOD = c_MAX + AW'(1);

   logic [AW-1:0] w_cnt;
   logic [AW-1:0] w_stp;
   logic [AW-1:0] w_step_mod;
   logic [AW-1:0] w_up_sum;
   logic [AW-1:0] w_up_wrap_raw;
   logic [AW-1:0] w_up_wrap;
   logic [AW-1:0] w_dn_wrap_raw;
   logic [AW-1:0] w_dn_wrap;

   assign w_cnt = AW'(i_count);
   assign w_stp = AW'(i_step);

   // Steps larger than the modulus wrap by their residue; reducing the step
   // first keeps both wrap results within one conditional subtraction.
   assign w_step_mod    = w_stp % c_MOD;

   assign w_up_sum      = w_cnt + w_stp;
   assign w_up_wrap_raw = w_cnt + w_step_mod;
   assign w_up_wrap     = (w_up_wrap_raw >= c_MOD) ? (w_up_wrap_raw - c_MOD)
                                                   : w_up_wrap_raw;

   assign w_dn_wrap_raw = w_cnt + c_MOD - w_step_mod;
   assign w_dn_wrap     = (w_dn_wrap_raw >= c_MOD) ? (w_dn_wrap_raw - c_MOD)
                                                   : w_dn_wrap_raw;

   // Select in-range result or boundary result for the requested direction
   always_comb begin
      o_next     = i_count;
      o_boundary = 1'b0;
      if (i_up_down == DIR_UP) begin
         if (w_up_sum <= c_MAX) begin
            o_next = WIDTH'(w_up_sum);
         end else begin
            o_boundary = 1'b1;
            o_next     = (i_mode == MODE_SAT) ? WIDTH'(c_MAX) : WIDTH'(w_up_wrap);
         end
      end else begin
         if (w_stp <= w_cnt) begin
            o_next = WIDTH'(w_cnt - w_stp);
         end else begin
            o_boundary = 1'b1;
            o_next     = (i_mode == MODE_SAT) ? '0 : WIDTH'(w_dn_wrap);
         end
      end
   end

endmodule : ctr_next_calc
`default_nettype wire

// File: rtl/updown_counter_mod.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter_mod
//  Purpose  : Parameterised up/down counter with variable step, wrap or
//             saturate boundary handling, preload, registered terminal-count
//             pulse, sticky overflow flag and registered zero flag.
//             Optional compare output enabled by macro UPDOWN_COUNTER_CMP_EN
//             (adds cmp_val input and registered cmp_match output).
//  Revision : 1.0  initial release
// ============================================================================
module updown_counter_mod
   import updown_counter_pkg::*;
#(
   parameter int          WIDTH   = 8,
   parameter int unsigned MAX_VAL = default_max(WIDTH),
   parameter int          STEP_W  = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              up_down,
   input  logic              preload,
   input  logic [WIDTH-1:0]  data,
   input  logic [STEP_W-1:0] step,
   input  logic              mode,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  count,
   output logic              tc,
   output logic              ovf,
   output logic              zero
`ifdef UPDOWN_COUNTER_CMP_EN
  ,input  logic [WIDTH-1:0]  cmp_val,
   output logic              cmp_match
`endif
);

   localparam logic [WIDTH-1:0] c_MAX_W = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_ovf;
   logic             r_zero;

   logic [WIDTH-1:0] w_calc_next;
   logic             w_calc_bnd;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_event;
   logic             w_ovf_nxt;

   ctr_next_calc #(
      .WIDTH   (WIDTH),
      .STEP_W  (STEP_W),
      .MAX_VAL (MAX_VAL)
   ) u_next_calc (
      .i_count    (r_count),
      .i_step     (step),
      .i_up_down  (up_down),
      .i_mode     (mode),
      .o_next     (w_calc_next),
      .o_boundary (w_calc_bnd)
   );

   // Out-of-range preload values clamp to the terminal value
   assign w_load_val = (data > c_MAX_W) ? c_MAX_W : data;

   // Next-state selection: preload beats enable, enable beats hold
   always_comb begin
      w_count_nxt = r_count;
      w_event     = 1'b0;
      if (preload) begin
         w_count_nxt = w_load_val;
      end else if (enable) begin
         w_count_nxt = w_calc_next;
         w_event     = w_calc_bnd;
      end
      // A boundary event outranks a simultaneous clear of the sticky flag
      if (w_event)
         w_ovf_nxt = 1'b1;
      else if (clr_ovf)
         w_ovf_nxt = 1'b0;
      else
         w_ovf_nxt = r_ovf;
   end

   // Counter state and status flags, asynchronously cleared by resetn
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b1;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_event;
         r_ovf   <= w_ovf_nxt;
         r_zero  <= (w_count_nxt == '0);
      end
   end

   assign count = r_count;
   assign tc    = r_tc;
   assign ovf   = r_ovf;
   assign zero  = r_zero;

`ifdef UPDOWN_COUNTER_CMP_EN
   logic r_cmp_match;

   // Match flag aligned with the count it describes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_cmp_match <= 1'b0;
      else
         r_cmp_match <= (w_count_nxt == cmp_val);
   end

   assign cmp_match = r_cmp_match;
`endif

endmodule : updown_counter_mod
`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updown_counter_mod
//  Purpose  : Self-checking bench for updown_counter_mod. Three instances
//             (MAX_VAL 9, 255, 99) share stimulus; an arithmetic reference
//             model predicts every output. Directed scenarios followed by
//             random stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_updown_counter_mod;

   logic       clk     = 1'b0;
   logic       resetn  = 1'b0;
   logic       enable  = 1'b0;
   logic       up_down = 1'b1;
   logic       preload = 1'b0;
   logic [7:0] data    = '0;
   logic [3:0] step    = '0;
   logic       mode    = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [7:0] cmp_val = '0;

   logic [7:0] o_cnt [3];
   logic       o_tc  [3];
   logic       o_ovf [3];
   logic       o_zero[3];
   logic       o_cmp [3];

   int  n_cmp = 0;
   int  n_bad = 0;

   int  maxv [3];
   int  m_cnt[3];
   bit  m_tc [3];
   bit  m_ovf[3];
   bit  m_cmp[3];

   always #5 clk = ~clk;

   updown_counter_mod #(.WIDTH(8), .MAX_VAL(9), .STEP_W(4)) u_dut0 (
      .clk(clk), .resetn(resetn), .enable(enable), .up_down(up_down),
      .preload(preload), .data(data), .step(step), .mode(mode),
      .clr_ovf(clr_ovf), .count(o_cnt[0]), .tc(o_tc[0]), .ovf(o_ovf[0]),
      .zero(o_zero[0])
`ifdef UPDOWN_COUNTER_CMP_EN
     ,.cmp_val(cmp_val), .cmp_match(o_cmp[0])
`endif
   );

   updown_counter_mod #(.WIDTH(8), .MAX_VAL(255), .STEP_W(4)) u_dut1 (
      .clk(clk), .resetn(resetn), .enable(enable), .up_down(up_down),
      .preload(preload), .data(data), .step(step), .mode(mode),
      .clr_ovf(clr_ovf), .count(o_cnt[1]), .tc(o_tc[1]), .ovf(o_ovf[1]),
      .zero(o_zero[1])
`ifdef UPDOWN_COUNTER_CMP_EN
     ,.cmp_val(cmp_val), .cmp_match(o_cmp[1])
`endif
   );

   updown_counter_mod #(.WIDTH(8), .MAX_VAL(99), .STEP_W(4)) u_dut2 (
      .clk(clk), .resetn(resetn), .enable(enable), .up_down(up_down),
      .preload(preload), .data(data), .step(step), .mode(mode),
      .clr_ovf(clr_ovf), .count(o_cnt[2]), .tc(o_tc[2]), .ovf(o_ovf[2]),
      .zero(o_zero[2])
`ifdef UPDOWN_COUNTER_CMP_EN
     ,.cmp_val(cmp_val), .cmp_match(o_cmp[2])
`endif
   );

`ifndef UPDOWN_COUNTER_CMP_EN
   assign o_cmp[0] = 1'b0;
   assign o_cmp[1] = 1'b0;
   assign o_cmp[2] = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: counter lives on the ring 0..max, so a step is plain
   // signed arithmetic followed by a range test and a modulo.
   task automatic model_edge();
      int m, s, evt;
      for (int k = 0; k < 3; k++) begin
         m   = maxv[k] + 1;
         evt = 0;
         if (preload) begin
            m_cnt[k] = (int'(data) > maxv[k]) ? maxv[k] : int'(data);
         end else if (enable) begin
            s = up_down ? m_cnt[k] + int'(step) : m_cnt[k] - int'(step);
            if (s < 0 || s > maxv[k]) begin
               evt = 1;
               if (mode) s = (s < 0) ? 0 : maxv[k];
               else      s = ((s % m) + m) % m;
            end
            m_cnt[k] = s;
         end
         m_tc[k] = (evt != 0);
         if (evt != 0)    m_ovf[k] = 1'b1;
         else if (clr_ovf) m_ovf[k] = 1'b0;
         m_cmp[k] = (m_cnt[k] == int'(cmp_val));
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_cnt[k] = 0;
         m_tc[k]  = 1'b0;
         m_ovf[k] = 1'b0;
         m_cmp[k] = 1'b0;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("count[%0d]", k), 32'(o_cnt[k]),  32'(m_cnt[k]));
         check($sformatf("tc[%0d]", k),    32'(o_tc[k]),   32'(m_tc[k]));
         check($sformatf("ovf[%0d]", k),   32'(o_ovf[k]),  32'(m_ovf[k]));
         check($sformatf("zero[%0d]", k),  32'(o_zero[k]), 32'(m_cnt[k] == 0));
`ifdef UPDOWN_COUNTER_CMP_EN
         check($sformatf("cmp[%0d]", k),   32'(o_cmp[k]),  32'(m_cmp[k]));
`endif
      end
   endtask

   // Inputs are set 1 time unit after an edge; outputs are sampled there too
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic drive(input logic pl, input logic en, input logic ud,
                        input logic md, input int st, input int d, input logic clr);
      preload = pl;
      enable  = en;
      up_down = ud;
      mode    = md;
      step    = 4'(st);
      data    = 8'(d);
      clr_ovf = clr;
   endtask

   initial begin
      maxv[0] = 9;
      maxv[1] = 255;
      maxv[2] = 99;
      model_reset();

      // Reset state
      #12;
      check_all();
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // Wrap up across MAX_VAL=9
      drive(1, 0, 1, 0, 1, 8, 0); tick();
      drive(0, 1, 1, 0, 1, 0, 0); tick();
      check("r042_cnt9", 32'(o_cnt[0]), 32'd9);
      check("r042_tc0",  32'(o_tc[0]),  32'd0);
      tick();
      check("r042_cnt0", 32'(o_cnt[0]), 32'd0);
      check("r042_tc1",  32'(o_tc[0]),  32'd1);
      check("r042_ovf1", 32'(o_ovf[0]), 32'd1);

      // Saturate up, repeated attempts at the limit
      drive(1, 0, 1, 1, 3, 8, 1); tick();
      drive(0, 1, 1, 1, 3, 0, 0); tick();
      check("r043_cnt9a", 32'(o_cnt[0]), 32'd9);
      check("r043_tc1a",  32'(o_tc[0]),  32'd1);
      tick();
      check("r043_cnt9b", 32'(o_cnt[0]), 32'd9);
      check("r043_tc1b",  32'(o_tc[0]),  32'd1);

      // Down wrap with MAX_VAL=255
      drive(1, 0, 0, 0, 4, 2, 0); tick();
      drive(0, 1, 0, 0, 4, 0, 0); tick();
      check("r044_cnt254", 32'(o_cnt[1]), 32'd254);
      check("r044_tc1",    32'(o_tc[1]),  32'd1);

      // Preload over range with enable: clamp, no step, ovf untouched
      drive(1, 1, 1, 0, 4, 200, 0); tick();
      check("r045_cnt99", 32'(o_cnt[2]), 32'd99);
      check("r045_tc0",   32'(o_tc[2]),  32'd0);
      check("r045_ovf",   32'(o_ovf[2]), 32'd1);

      // Set wins over clear
      drive(0, 0, 1, 0, 1, 0, 1); tick();
      check("r046_clr", 32'(o_ovf[0]), 32'd0);
      drive(0, 1, 1, 0, 1, 0, 1); tick();
      check("r046_setwins", 32'(o_ovf[0]), 32'd1);
      drive(0, 0, 1, 0, 1, 0, 1); tick();
      check("r046_cleared", 32'(o_ovf[0]), 32'd0);

      // step=0 holds with no event
      drive(0, 1, 1, 0, 0, 0, 0); tick();
      check("hold_step0_tc", 32'(o_tc[0]), 32'd0);

      // Asynchronous reset mid-count at 57
      drive(1, 0, 1, 0, 1, 56, 0); tick();
      drive(0, 1, 1, 0, 1, 0, 0); tick();
      check("r047_at57", 32'(o_cnt[1]), 32'd57);
      #3;
      resetn = 1'b0;
      model_reset();
      #1;
      check("r047_cnt0",  32'(o_cnt[1]),  32'd0);
      check("r047_zero1", 32'(o_zero[1]), 32'd1);
      check_all();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      drive(0, 1, 1, 0, 1, 0, 0); tick();
      check("r035_from0", 32'(o_cnt[0]), 32'd1);

      // Compare sequence: cmp_val=5, count up from 3
      cmp_val = 8'd5;
      drive(1, 0, 1, 0, 1, 3, 0); tick();
      drive(0, 1, 1, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) tick();

      // Random stimulus
      for (int i = 0; i < 500; i++) begin
         preload = ($urandom_range(0, 9) == 0);
         enable  = ($urandom_range(0, 3) != 0);
         up_down = 1'($urandom);
         mode    = 1'($urandom);
         step    = 4'($urandom_range(0, 15));
         data    = 8'($urandom);
         clr_ovf = ($urandom_range(0, 7) == 0);
         cmp_val = 8'($urandom_range(0, 12));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_updown_counter_mod
`default_nettype wire
